// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART parity datapath
//
// Contents:
//   par_mode_e  : parity mode encoding, matching the 2-bit mode input
//   pe_state_e  : parity engine FSM states
//   parity_bit  : final parity bit from mode, accumulated XOR and enable
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOADED = 2'b01,
        CALC   = 2'b10
    } pe_state_e;

    // A disabled parity bit always reads 0, whatever the mode.
    function automatic logic parity_bit(input par_mode_e m, input logic xor_acc,
                                        input logic en);
        logic res;
        res = 1'b0;
        if (en) begin
            case (m)
                PAR_EVEN:  res = xor_acc;
                PAR_ODD:   res = ~xor_acc;
                PAR_MARK:  res = 1'b1;
                PAR_SPACE: res = 1'b0;
                default:   res = xor_acc;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_err_counter.sv
// rtl/uart_err_counter.sv - saturating error counter with sticky flag and clear priority
//
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   inc         : count one error this cycle
//   clr         : clear count and sticky flag; wins over a same-cycle inc
//   err_sticky  : set by any inc, held until clr or reset
//   err_cnt     : number of incs, saturating at all-ones
module uart_err_counter #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;

    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (inc) begin
            sticky_d = 1'b1;
            if (cnt_q != {ERR_CNT_W{1'b1}}) begin
                cnt_d = cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign err_cnt    = cnt_q;
    assign err_sticky = sticky_q;

endmodule

// File: rtl/uart_parity_engine.sv
// rtl/uart_parity_engine.sv - bit-serial parity generator/checker with error reporting
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   data_in         : character to protect or check (LSB first)
//   data_len        : active bit count; 0 or > DATA_W means DATA_W
//   mode            : 00 even, 01 odd, 10 mark, 11 space
//   par_en, chk     : parity enable, check (1) / generate (0)
//   rx_par          : received parity bit compared in check mode
//   load, signal    : capture strobe, compute strobe (ignored when both high)
//   err_clr         : clears err_sticky/err_cnt
//   parity          : computed parity, held until next accepted load
//   valid, par_err  : one-cycle result strobe and coincident mismatch pulse
//   busy            : high while serially computing
//   err_sticky      : any parity error since last clear
//   err_cnt         : saturating parity error count
module uart_parity_engine
    import uart_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int ERR_CNT_W = 8,
    localparam int LEN_W     = $clog2(DATA_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [LEN_W-1:0]     data_len,
    input  logic [1:0]           mode,
    input  logic                 par_en,
    input  logic                 chk,
    input  logic                 rx_par,
    input  logic                 load,
    input  logic                 signal,
    input  logic                 err_clr,
    output logic                 parity,
    output logic                 valid,
    output logic                 busy,
    output logic                 par_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    pe_state_e            state_q, state_d;
    logic [DATA_W-1:0]    store_q, store_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    par_mode_e            mode_q, mode_d;
    logic                 par_en_q, par_en_d;
    logic                 chk_q, chk_d;
    logic                 rx_par_q, rx_par_d;
    logic                 acc_q, acc_d;
    logic                 parity_q, parity_d;
    logic                 valid_q, valid_d;
    logic                 par_err_q, par_err_d;

    logic [LEN_W-1:0]     len_eff;
    logic                 cur_bit;
    logic                 acc_next;
    logic                 last_bit;
    logic                 result;
    logic                 load_ok;
    logic                 start_ok;

    // Out-of-range lengths fall back to the full character so the counter
    // always terminates within DATA_W cycles.
    always_comb begin
        len_eff = data_len;
        if (data_len == '0 || data_len > LEN_W'(DATA_W)) begin
            len_eff = LEN_W'(DATA_W);
        end
    end

    // Explicit bit mux keeps the select width independent of LEN_W.
    always_comb begin
        cur_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == LEN_W'(i)) begin
                cur_bit = store_q[i];
            end
        end
    end

    assign acc_next = acc_q ^ cur_bit;
    assign last_bit = (cnt_q == len_q - LEN_W'(1));
    assign result   = parity_bit(mode_q, acc_next, par_en_q);

    assign load_ok  = load && !signal && (state_q == IDLE || state_q == LOADED);
    assign start_ok = signal && !load && (state_q == LOADED);

    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        par_en_d  = par_en_q;
        chk_d     = chk_q;
        rx_par_d  = rx_par_q;
        acc_d     = acc_q;
        parity_d  = parity_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;

        case (state_q)
            IDLE, LOADED: begin
                if (load_ok) begin
                    store_d  = data_in;
                    len_d    = len_eff;
                    mode_d   = par_mode_e'(mode);
                    par_en_d = par_en;
                    chk_d    = chk;
                    rx_par_d = rx_par;
                    parity_d = 1'b0;
                    state_d  = LOADED;
                end else if (start_ok) begin
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Mark/space still walk every bit so latency is mode-independent.
                acc_d = acc_next;
                cnt_d = cnt_q + LEN_W'(1);
                if (last_bit) begin
                    parity_d  = result;
                    valid_d   = 1'b1;
                    par_err_d = par_en_q && chk_q && (result != rx_par_q);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            store_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= PAR_EVEN;
            par_en_q  <= 1'b0;
            chk_q     <= 1'b0;
            rx_par_q  <= 1'b0;
            acc_q     <= 1'b0;
            parity_q  <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            store_q   <= store_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            par_en_q  <= par_en_d;
            chk_q     <= chk_d;
            rx_par_q  <= rx_par_d;
            acc_q     <= acc_d;
            parity_q  <= parity_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
        end
    end

    // Counter is fed on the same edge that raises par_err, so err_cnt and
    // err_sticky already reflect the error while par_err/valid are high.
    uart_err_counter #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_counter (
        .clk        (clk),
        .rst        (rst),
        .inc        (par_err_d),
        .clr        (err_clr),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    assign parity  = parity_q;
    assign valid   = valid_q;
    assign busy    = (state_q == CALC);
    assign par_err = par_err_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// tb/tb_uart_parity_engine.sv - directed self-checking bench for uart_parity_engine
module tb_uart_parity_engine;

    localparam int DATA_W    = 8;
    localparam int ERR_CNT_W = 2;
    localparam int LEN_W     = 4;

    localparam logic [1:0] M_EVEN  = 2'b00;
    localparam logic [1:0] M_ODD   = 2'b01;
    localparam logic [1:0] M_MARK  = 2'b10;
    localparam logic [1:0] M_SPACE = 2'b11;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DATA_W-1:0]    data_in;
    logic [LEN_W-1:0]     data_len;
    logic [1:0]           mode;
    logic                 par_en, chk, rx_par, load, signal, err_clr;
    logic                 parity, valid, busy, par_err, err_sticky;
    logic [ERR_CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int             lat_edges;
    int             busy_cnt;
    logic           r_parity, r_par_err, r_sticky;
    logic [ERR_CNT_W-1:0] r_cnt;

    always #5 clk = ~clk;

    uart_parity_engine #(
        .DATA_W    (DATA_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_len   (data_len),
        .mode       (mode),
        .par_en     (par_en),
        .chk        (chk),
        .rx_par     (rx_par),
        .load       (load),
        .signal     (signal),
        .err_clr    (err_clr),
        .parity     (parity),
        .valid      (valid),
        .busy       (busy),
        .par_err    (par_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    task automatic do_load(input logic [7:0] d, input logic [3:0] len, input logic [1:0] m,
                           input logic pe, input logic c, input logic rp);
        @(negedge clk);
        data_in = d; data_len = len; mode = m; par_en = pe; chk = c; rx_par = rp; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Pulses signal, then counts edges until valid; samples the result in the valid cycle.
    task automatic run_calc(input bit clr_at_end, input bit inject_load);
        signal = 1'b1;
        @(negedge clk);
        signal    = 1'b0;
        lat_edges = 0;
        busy_cnt  = 0;
        while (valid !== 1'b1 && lat_edges < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (inject_load && lat_edges == 2) begin data_in = 8'h55; load = 1'b1; end
            if (inject_load && lat_edges == 3) load = 1'b0;
            if (clr_at_end && lat_edges == 7) err_clr = 1'b1;
            @(negedge clk);
            lat_edges++;
        end
        r_parity  = parity;
        r_par_err = par_err;
        r_sticky  = err_sticky;
        r_cnt     = err_cnt;
        err_clr   = 1'b0;
        load      = 1'b0;
        if (lat_edges >= 40) begin
            n_checks++; n_fail++;
            $display("FAIL valid_timeout: no valid within %0d edges", lat_edges);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({parity, valid, busy, par_err, err_sticky, err_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %b required 0", {parity, valid, busy, par_err, err_sticky, err_cnt}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_generate();
        do_load(8'hB5, 4'd8, M_EVEN, 1'b1, 1'b0, 1'b0);
        run_calc(1'b0, 1'b0);
        n_checks++; if (lat_edges !== 8) begin n_fail++; $display("FAIL gen_latency: got %0d required 8", lat_edges); end
        n_checks++; if (busy_cnt !== 8) begin n_fail++; $display("FAIL gen_busy_cycles: got %0d required 8", busy_cnt); end
        n_checks++; if (r_parity !== 1'b1) begin n_fail++; $display("FAIL gen_even_B5: got %b required 1", r_parity); end
        @(negedge clk);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle: got %b required 0", valid); end
        n_checks++; if (parity !== 1'b1) begin n_fail++; $display("FAIL parity_hold: got %b required 1", parity); end
        do_load(8'hB5, 4'd8, M_ODD, 1'b1, 1'b0, 1'b0);
        n_checks++; if (parity !== 1'b0) begin n_fail++; $display("FAIL parity_clear_on_load: got %b required 0", parity); end
        run_calc(1'b0, 1'b0);
        n_checks++; if (r_parity !== 1'b0) begin n_fail++; $display("FAIL gen_odd_B5: got %b required 0", r_parity); end
    endtask

    task automatic test_length();
        logic [3:0] lens [3] = '{4'd4, 4'd0, 4'd12};
        logic       exps [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_load(8'hB5, lens[i], M_EVEN, 1'b1, 1'b0, 1'b0);
            run_calc(1'b0, 1'b0);
            n_checks++; if (r_parity !== exps[i]) begin n_fail++;
                $display("FAIL len_%0d_parity: got %b required %b", lens[i], r_parity, exps[i]); end
        end
        n_checks++; if (lat_edges !== 8) begin n_fail++; $display("FAIL len12_latency: got %0d required 8", lat_edges); end
    endtask

    task automatic test_check();
        do_load(8'h0F, 4'd8, M_EVEN, 1'b1, 1'b1, 1'b1);
        run_calc(1'b0, 1'b0);
        n_checks++; if ({r_par_err, r_sticky, r_cnt} !== {1'b1, 1'b1, 2'd1}) begin n_fail++;
            $display("FAIL chk_mismatch: got err=%b sticky=%b cnt=%0d required 1 1 1", r_par_err, r_sticky, r_cnt); end
        @(negedge clk);
        n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL par_err_one_cycle: got %b required 0", par_err); end
        do_load(8'h0F, 4'd8, M_EVEN, 1'b1, 1'b1, 1'b0);
        run_calc(1'b0, 1'b0);
        n_checks++; if ({r_par_err, r_sticky, r_cnt} !== {1'b0, 1'b1, 2'd1}) begin n_fail++;
            $display("FAIL chk_match: got err=%b sticky=%b cnt=%0d required 0 1 1", r_par_err, r_sticky, r_cnt); end
    endtask

    task automatic test_saturate();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        n_checks++; if ({err_sticky, err_cnt} !== 3'b000) begin n_fail++;
            $display("FAIL err_clr_idle: got sticky=%b cnt=%0d required 0 0", err_sticky, err_cnt); end
        for (int i = 0; i < 5; i++) begin
            do_load(8'h0F, 4'd8, M_EVEN, 1'b1, 1'b1, 1'b1);
            run_calc(1'b0, 1'b0);
        end
        n_checks++; if (r_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_after_5: got %0d required 3", r_cnt); end
        do_load(8'h0F, 4'd8, M_EVEN, 1'b1, 1'b1, 1'b1);
        run_calc(1'b0, 1'b0);
        n_checks++; if ({r_par_err, r_cnt} !== {1'b1, 2'd3}) begin n_fail++;
            $display("FAIL sat_hold: got err=%b cnt=%0d required 1 3", r_par_err, r_cnt); end
        do_load(8'h0F, 4'd8, M_EVEN, 1'b1, 1'b1, 1'b1);
        run_calc(1'b1, 1'b0);
        n_checks++; if ({r_par_err, r_sticky, r_cnt} !== {1'b1, 1'b0, 2'd0}) begin n_fail++;
            $display("FAIL clr_priority: got err=%b sticky=%b cnt=%0d required 1 0 0", r_par_err, r_sticky, r_cnt); end
    endtask

    task automatic test_fixed_modes();
        logic [1:0] ms  [3] = '{M_MARK, M_SPACE, M_EVEN};
        logic       pes [3] = '{1'b1, 1'b1, 1'b0};
        logic       cks [3] = '{1'b0, 1'b0, 1'b1};
        logic       exps[3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_load(8'hFF, 4'd8, ms[i], pes[i], cks[i], cks[i]);
            run_calc(1'b0, 1'b0);
            n_checks++; if ({r_parity, r_par_err, lat_edges[3:0]} !== {exps[i], 1'b0, 4'd8}) begin n_fail++;
                $display("FAIL fixed_mode_%0d: got par=%b err=%b lat=%0d required %b 0 8", i, r_parity, r_par_err, lat_edges, exps[i]); end
        end
    endtask

    task automatic test_load_during_calc();
        do_load(8'hB5, 4'd8, M_EVEN, 1'b1, 1'b0, 1'b0);
        run_calc(1'b0, 1'b1);
        n_checks++; if ({r_parity, lat_edges[3:0]} !== {1'b1, 4'd8}) begin n_fail++;
            $display("FAIL load_in_calc: got par=%b lat=%0d required 1 8", r_parity, lat_edges); end
    endtask

    task automatic test_load_and_signal();
        do_load(8'hB5, 4'd8, M_EVEN, 1'b1, 1'b0, 1'b0);
        data_in = 8'h00; load = 1'b1; signal = 1'b1;
        @(negedge clk);
        load = 1'b0; signal = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_high_busy: got %b required 0", busy); end
        run_calc(1'b0, 1'b0);
        n_checks++; if (r_parity !== 1'b1) begin n_fail++; $display("FAIL both_high_kept_data: got %b required 1", r_parity); end
    endtask

    task automatic test_reset_mid_calc();
        do_load(8'h0F, 4'd8, M_EVEN, 1'b1, 1'b1, 1'b1);
        run_calc(1'b0, 1'b0);
        n_checks++; if (r_cnt !== 2'd1) begin n_fail++; $display("FAIL pre_rst_cnt: got %0d required 1", r_cnt); end
        do_load(8'hB5, 4'd8, M_EVEN, 1'b1, 1'b1, 1'b0);
        signal = 1'b1;
        @(negedge clk); signal = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_rst_busy: got %b required 1", busy); end
        rst = 1'b0;
        #1;
        n_checks++; if ({parity, valid, busy, par_err, err_sticky, err_cnt} !== '0) begin n_fail++;
            $display("FAIL rst_mid_calc: got %b required 0", {parity, valid, busy, par_err, err_sticky, err_cnt}); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); signal = 1'b1;
        @(negedge clk); signal = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL signal_in_idle: got %b required 0", busy); end
        do_load(8'hB5, 4'd8, M_EVEN, 1'b1, 1'b0, 1'b0);
        run_calc(1'b0, 1'b0);
        n_checks++; if ({r_parity, lat_edges[3:0]} !== {1'b1, 4'd8}) begin n_fail++;
            $display("FAIL post_rst_run: got par=%b lat=%0d required 1 8", r_parity, lat_edges); end
    endtask

    initial begin
        rst = 1'b0; data_in = '0; data_len = '0; mode = '0; par_en = 1'b0; chk = 1'b0;
        rx_par = 1'b0; load = 1'b0; signal = 1'b0; err_clr = 1'b0;
        test_reset();
        test_generate();
        test_length();
        test_check();
        test_saturate();
        test_fixed_modes();
        test_load_during_calc();
        test_load_and_signal();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_parity_engine.md
Name: uart_parity_engine

Overview:
Parametrised, bit-serial parity generator/checker for the UART datapath; successor to the fixed 8-bit load/compute parity cell.
- Adds runtime-programmable character length, four parity modes, a parity-enable, a check mode against a received parity bit, and sticky/saturating error reporting.
- Sits between the TX/RX shift registers and the UART control FSM.
- Uses the same load/signal strobe protocol, plus busy/valid status.

Parameters:
DATA_W, 8, maximum character width in bits (>=2)
ERR_CNT_W, 8, width of saturating parity-error counter
LEN_W, $clog2(DATA_W+1) (localparam), width of data_len

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
data_in  input  DATA_W  character to protect/check
data_len  input  LEN_W  active bits, LSB-aligned; sampled on load
mode  input  2  00 even, 01 odd, 10 mark (1), 11 space (0); sampled on load
par_en  input  1  parity enabled; sampled on load
chk  input  1  1 = check mode, 0 = generate mode; sampled on load
rx_par  input  1  received parity bit; sampled on load
load  input  1  capture strobe
signal  input  1  compute strobe
err_clr  input  1  clears err_sticky and err_cnt
parity  output  1  computed parity bit
valid  output  1  one-cycle result strobe
busy  output  1  high in CALC
par_err  output  1  one-cycle mismatch pulse, coincident with valid
err_sticky  output  1  set on any par_err
err_cnt  output  ERR_CNT_W  saturating count of par_err pulses

Behaviour:
- Reset (rst=0, async): state IDLE; store, acc and bit counter cleared; all outputs 0.
- FSM states: IDLE, LOADED, CALC.
- load=1 and signal=0 in IDLE or LOADED:
  - capture data_in, data_len, mode, par_en, chk and rx_par.
  - clear parity; go to LOADED.
  - A reload in LOADED overwrites the captured values.
- signal=1 and load=0 in LOADED: acc<=0, cnt<=0, go to CALC; busy=1 from the next cycle.
- signal in IDLE: ignored.
- load and signal both high: ignored in every state.
- CALC: one bit per edge, acc<=acc^store[cnt], cnt++.
  - On the edge that consumes bit len-1: registered parity is updated, valid=1 for one cycle, state goes to IDLE.
- Latency: valid is high in the cycle following the len-th edge after the edge that sampled signal.
- Effective length: data_len=0 or data_len>DATA_W is treated as DATA_W. Bits at or above len are never used.
- Parity by mode:
  - even: reduction XOR of the active bits.
  - odd: its inverse.
  - mark: 1.
  - space: 0.
  - CALC still runs its full len cycles for mark and space, so latency is uniform.
- par_en=0: parity=0, par_err never asserts; valid is still produced.
- Check mode (chk=1, par_en=1): par_err=(parity!=rx_par), pulsed with valid.
  - On mismatch: err_sticky<=1 and err_cnt increments, saturating at all-ones.
- parity holds its value until the next accepted load or reset.
- load or signal during CALC: ignored, no effect on the result.
- err_clr:
  - Takes priority over a same-cycle increment/set; the cleared result is 0.
  - The par_err pulse is still driven in that cycle.
- Reset mid-CALC: immediate return to IDLE with all outputs 0; the pending result is discarded.

Decomposition:
- Package uart_pkg:
  - parity mode enum and encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE).
  - parity-engine state enum (IDLE, LOADED, CALC).
- Sub-module uart_err_counter (ERR_CNT_W): saturating counter with clear-priority and sticky flag. It is reused later by the framing-error logic.

Test Plan:
- DATA_W=8, load 0xB5, len=8, even, par_en=1, chk=0, then signal -> valid after 8 edges, parity=1, busy high 8 cycles. Repeat with odd -> parity=0.
- load 0xB5, len=4, even -> parity=0 (only 4'b0101 used). Repeat with len=0 and with len=12 -> treated as 8, parity=1.
- Check mode: load 0x0F, even, rx_par=1, signal -> par_err=1 with valid, err_sticky=1, err_cnt=1. Then rx_par=0 -> par_err=0, err_cnt stays 1.
- ERR_CNT_W=2, five mismatching checks -> err_cnt=3. err_cnt holds at 3 on a further error. err_clr asserted in the same cycle as a 6th error -> err_cnt=0, err_sticky=0, par_err pulse still seen.
- Mark, space and par_en=0, with data 0xFF len=8 -> parity 1, 0 and 0 respectively. Each gives valid after 8 edges; no par_err even with chk=1, rx_par=1 when par_en=0.
- Robustness:
  - load 0x55 during CALC -> result unchanged.
  - load and signal both high -> no state change.
  - rst low mid-CALC (cycle 3) -> parity, valid, busy, err_cnt all 0, state IDLE. A fresh load/signal then completes normally.
